// File: rtl/spi_word_sequencer.sv
// spi_word_sequencer
// Streams 32-bit words from a synchronous-read memory out to a byte-wide SPI
// master, LSB byte first, over an inclusive word-aligned address range.
//
// Ports
//   clk         system clock, all state changes on the rising edge
//   rst         asynchronous active-low reset
//   start       one-cycle transfer request, honoured only while idle
//   abort       stop once the byte currently on the SPI has completed
//   start_addr  byte address of the first word (inclusive, word aligned)
//   end_addr    byte address of the last word (inclusive, word aligned)
//   m_addr      word-aligned memory read address
//   m_re        memory read strobe, m_rd is valid the following cycle
//   m_rd        memory read data
//   spi_wd      byte presented to the SPI master
//   spi_send    one-cycle send trigger to the SPI master
//   spi_busy    SPI master busy, rises the cycle after spi_send
//   busy        transfer in progress
//   done        one-cycle pulse when an accepted start has finished
//   err         sticky: last start had a bad address range
//   aborted     sticky: last transfer was ended by abort
//   dbg_state   current FSM state, for observation only
//
// Handshake: spi_send is a single-cycle strobe that is only raised while
// spi_busy is low; the master acknowledges by holding spi_busy high from the
// next cycle until the byte is complete. m_re is likewise a one-cycle strobe
// with fixed one-cycle read latency and no back-pressure.
module spi_word_sequencer #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] end_addr,
  output logic [AW-1:0] m_addr,
  output logic          m_re,
  input  logic [31:0]   m_rd,
  output logic [7:0]    spi_wd,
  output logic          spi_send,
  input  logic          spi_busy,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          aborted,
  output logic [2:0]    dbg_state
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_LOAD     = 3'd2;
  localparam logic [2:0] S_SEND     = 3'd3;
  localparam logic [2:0] S_WAIT_SPI = 3'd4;
  localparam logic [2:0] S_NEXT     = 3'd5;
  localparam logic [2:0] S_FINISH   = 3'd6;

  logic [2:0]    state_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] end_q;
  logic [31:0]   shift_q;
  logic [1:0]    cnt_q;
  logic          skip_q;
  logic          abort_seen_q;
  logic          err_q;
  logic          aborted_q;
  logic          range_bad;
  logic          send_now;

  assign range_bad = (start_addr[1:0] != 2'b00) || (end_addr[1:0] != 2'b00) ||
                     (end_addr < start_addr);

  assign send_now = (state_q == S_SEND) && !spi_busy;

  // The current byte always sits in shift_q[7:0]; the shift happens when
  // moving on to the next byte, so spi_wd stays stable for the whole byte
  // time after the send strobe.
  assign spi_wd    = shift_q[7:0];
  assign spi_send  = send_now;
  assign m_re      = (state_q == S_FETCH);
  assign m_addr    = addr_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign done      = (state_q == S_FINISH);
  assign err       = err_q;
  assign aborted   = aborted_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      end_q        <= '0;
      shift_q      <= '0;
      cnt_q        <= '0;
      skip_q       <= 1'b0;
      abort_seen_q <= 1'b0;
      err_q        <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      // Abort is remembered from any active state and acted on only when the
      // byte on the wire has completed.
      if (busy && abort) begin
        abort_seen_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q       <= {start_addr[AW-1:2], 2'b00};
            end_q        <= end_addr;
            err_q        <= range_bad;
            aborted_q    <= 1'b0;
            abort_seen_q <= 1'b0;
            state_q      <= range_bad ? S_FINISH : S_FETCH;
          end
        end

        S_FETCH: begin
          state_q <= S_LOAD;
        end

        S_LOAD: begin
          shift_q <= m_rd;
          cnt_q   <= 2'd0;
          state_q <= S_SEND;
        end

        S_SEND: begin
          if (!spi_busy) begin
            skip_q  <= 1'b1;
            state_q <= S_WAIT_SPI;
          end
        end

        S_WAIT_SPI: begin
          // The master only raises spi_busy the cycle after the send, so the
          // first cycle here cannot be trusted to show the byte in flight.
          if (skip_q) begin
            skip_q <= 1'b0;
          end else if (!spi_busy) begin
            if (abort_seen_q || abort) begin
              aborted_q <= 1'b1;
              state_q   <= S_FINISH;
            end else if (cnt_q != 2'd3) begin
              cnt_q   <= cnt_q + 2'd1;
              shift_q <= {8'h00, shift_q[31:8]};
              state_q <= S_SEND;
            end else begin
              state_q <= S_NEXT;
            end
          end
        end

        S_NEXT: begin
          // Compare before incrementing so a range ending at the top word
          // never wraps the address.
          if (addr_q == end_q) begin
            state_q <= S_FINISH;
          end else begin
            addr_q  <= addr_q + AW'(4);
            state_q <= S_FETCH;
          end
        end

        S_FINISH: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_word_sequencer.sv
// tb_spi_word_sequencer
// Directed and randomized checks of spi_word_sequencer. A memory model with
// one-cycle read latency and an SPI master model with random byte times feed
// logs that are compared against byte/address streams built from the memory
// contents and the requested range.
module tb_spi_word_sequencer;

  localparam int AW = 32;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] end_addr = '0;
  logic [AW-1:0] m_addr;
  logic          m_re;
  logic [31:0]   m_rd = '0;
  logic [7:0]    spi_wd;
  logic          spi_send;
  logic          spi_busy = 1'b0;
  logic          busy;
  logic          done;
  logic          err;
  logic          aborted;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  spi_word_sequencer #(.AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .m_addr     (m_addr),
    .m_re       (m_re),
    .m_rd       (m_rd),
    .spi_wd     (spi_wd),
    .spi_send   (spi_send),
    .spi_busy   (spi_busy),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .aborted    (aborted),
    .dbg_state  (dbg_state)
  );

  // ---------------- environment models ----------------
  logic [31:0] mem [64];
  int          busy_left = 0;
  int          cyc = 0;
  int          n_overlap = 0;

  logic [7:0]  got_q[$];
  logic [31:0] got_addr_q[$];
  int          start_t_q[$];
  int          send_t_q[$];
  int          mre_t_q[$];
  int          done_t_q[$];

  always @(posedge clk) begin
    if (m_re) m_rd <= mem[m_addr[7:2]];
  end

  always @(posedge clk) begin
    if (spi_send) begin
      busy_left <= $urandom_range(1, 5);
      spi_busy  <= 1'b1;
    end else if (busy_left > 1) begin
      busy_left <= busy_left - 1;
    end else begin
      busy_left <= 0;
      spi_busy  <= 1'b0;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (start && !busy) start_t_q.push_back(cyc);
    if (spi_send) begin
      got_q.push_back(spi_wd);
      send_t_q.push_back(cyc);
    end
    if (m_re) begin
      got_addr_q.push_back(m_addr);
      mre_t_q.push_back(cyc);
    end
    if (done) done_t_q.push_back(cyc);
    if (spi_send && m_re) n_overlap <= n_overlap + 1;
  end

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [2:0]  idle_state;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: every word in [s, e] in ascending order, bytes LSB first.
  task automatic build_exp(input logic [31:0] s, input logic [31:0] e);
    logic [31:0] w;
    exp_q.delete();
    exp_addr_q.delete();
    for (longint a = s; a <= longint'(e); a += 4) begin
      exp_addr_q.push_back(a[31:0]);
      w = mem[a[7:2]];
      for (int b = 0; b < 4; b++) exp_q.push_back(8'(w >> (8 * b)));
    end
  endtask

  task automatic check_stream(input string tag);
    int n;
    check({tag, "_nbytes"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_byte"}, got_q[i], exp_q[i]);
    check({tag, "_nreads"}, got_addr_q.size(), exp_addr_q.size());
    n = (got_addr_q.size() < exp_addr_q.size()) ? got_addr_q.size() : exp_addr_q.size();
    for (int i = 0; i < n; i++) check({tag, "_addr"}, got_addr_q[i], exp_addr_q[i]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [31:0] s, input logic [31:0] e);
    got_q.delete();
    got_addr_q.delete();
    start_t_q.delete();
    send_t_q.delete();
    mre_t_q.delete();
    done_t_q.delete();
    @(negedge clk);
    start_addr = s;
    end_addr   = e;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_t_q.size() != 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_done_timeout"}, ok, 1'b1);
    repeat (4) @(negedge clk);
    check({tag, "_done_count"}, done_t_q.size(), 1);
    check({tag, "_busy_after"}, busy, 1'b0);
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (got_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_bytes_timeout"}, ok, 1'b1);
  endtask

  task automatic xfer_ok(input string tag, input logic [31:0] s, input logic [31:0] e);
    build_exp(s, e);
    do_start(s, e);
    check({tag, "_busy_on"}, busy, 1'b1);
    wait_done(tag, (exp_addr_q.size() * 4 * 10) + 50);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_aborted"}, aborted, 1'b0);
    check({tag, "_state_idle"}, dbg_state, idle_state);
    check_stream(tag);
  endtask

  task automatic xfer_bad(input string tag, input logic [31:0] s, input logic [31:0] e);
    int lat;
    do_start(s, e);
    wait_done(tag, 20);
    lat = (done_t_q.size() > 0 && start_t_q.size() > 0) ? done_t_q[0] - start_t_q[0] : 99;
    check({tag, "_done_within_3"}, (lat >= 1 && lat <= 3), 1'b1);
    check({tag, "_err"}, err, 1'b1);
    check({tag, "_sends"}, got_q.size(), 0);
    check({tag, "_reads"}, got_addr_q.size(), 0);
  endtask

  task automatic load_demo_words();
    mem[16] = 32'hdeadc0de;
    mem[17] = 32'hdeadbeef;
    mem[18] = 32'hc001c0de;
    mem[19] = 32'hc001beef;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n_at_reset;
    int lat;
    logic [31:0] s;
    logic [31:0] e;
    logic [7:0] demo [16];

    for (int i = 0; i < 64; i++) mem[i] = $urandom;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_aborted", aborted, 1'b0);
    check("rst_m_re", m_re, 1'b0);
    check("rst_spi_send", spi_send, 1'b0);
    check("rst_spi_wd", spi_wd, 8'h00);
    check("rst_m_addr", m_addr, 32'h0);
    idle_state = dbg_state;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Demo stream, with the byte sequence also checked against literals.
    load_demo_words();
    demo = '{8'hde, 8'hc0, 8'had, 8'hde, 8'hef, 8'hbe, 8'had, 8'hde,
             8'hde, 8'hc0, 8'h01, 8'hc0, 8'hef, 8'hbe, 8'h01, 8'hc0};
    xfer_ok("demo", 32'h40, 32'h4c);
    for (int i = 0; i < 16; i++) check("demo_literal", (i < got_q.size()) ? got_q[i] : 8'hxx, demo[i]);
    lat = (mre_t_q.size() > 0 && start_t_q.size() > 0) ? mre_t_q[0] - start_t_q[0] : 99;
    check("lat_m_re", lat, 1);
    lat = (send_t_q.size() > 0 && start_t_q.size() > 0) ? send_t_q[0] - start_t_q[0] : 99;
    check("lat_spi_send", lat, 3);

    // Single word.
    mem[16] = 32'h11223344;
    xfer_ok("single", 32'h40, 32'h40);

    // Bad ranges, then a good start clears err.
    xfer_bad("bad_start_align", 32'h42, 32'h4c);
    xfer_bad("bad_end_align", 32'h40, 32'h4e);
    xfer_bad("bad_order", 32'h50, 32'h40);
    xfer_ok("err_clear", 32'h80, 32'h84);

    // Abort during the second byte of a 4-word transfer.
    build_exp(32'h80, 32'h8c);
    do_start(32'h80, 32'h8c);
    wait_bytes("abort", 2, 100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done("abort", 100);
    check("abort_nbytes", got_q.size(), 2);
    check("abort_byte0", (got_q.size() > 0) ? got_q[0] : 8'hxx, exp_q[0]);
    check("abort_byte1", (got_q.size() > 1) ? got_q[1] : 8'hxx, exp_q[1]);
    check("abort_flag", aborted, 1'b1);
    check("abort_err", err, 1'b0);
    xfer_ok("abort_clear", 32'hc0, 32'hc8);

    // Abort while idle does nothing; abort together with start is ignored.
    @(negedge clk);
    abort = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_abort_busy", busy, 1'b0);
    check("idle_abort_done", done, 1'b0);
    build_exp(32'h10, 32'h14);
    got_q.delete();
    got_addr_q.delete();
    start_t_q.delete();
    done_t_q.delete();
    start_addr = 32'h10;
    end_addr   = 32'h14;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    wait_done("start_abort", 150);
    check("start_abort_aborted", aborted, 1'b0);
    check_stream("start_abort");

    // Second start while busy is ignored.
    load_demo_words();
    build_exp(32'h40, 32'h4c);
    do_start(32'h40, 32'h4c);
    wait_bytes("restart", 3, 100);
    start_addr = 32'h0;
    end_addr   = 32'h0;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("restart", 300);
    check_stream("restart");

    // Range ending at the top word must not wrap.
    xfer_ok("top", 32'hfffffff8, 32'hfffffffc);

    // Reset during the third word.
    load_demo_words();
    do_start(32'h40, 32'h4c);
    wait_bytes("reset", 9, 300);
    n_at_reset = got_q.size();
    rst = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_err", err, 1'b0);
    check("midrst_aborted", aborted, 1'b0);
    check("midrst_m_re", m_re, 1'b0);
    check("midrst_spi_send", spi_send, 1'b0);
    check("midrst_spi_wd", spi_wd, 8'h00);
    check("midrst_m_addr", m_addr, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check("midrst_no_send", got_q.size(), n_at_reset);
    xfer_ok("after_rst", 32'h40, 32'h4c);

    // Random ranges and contents.
    for (int k = 0; k < 8; k++) begin
      int idx;
      int nw;
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      nw  = $urandom_range(1, 4);
      idx = $urandom_range(0, 64 - nw);
      s   = 32'(idx * 4);
      e   = 32'((idx + nw - 1) * 4);
      xfer_ok("rand", s, e);
    end

    check("no_send_with_m_re", n_overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
